// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and FSM encoding for the register-file write-port arbiter.
package rf_wb_arbiter_pkg;

   localparam int P_DW   = 32;
   localparam int P_AW   = 5;
   localparam int P_NREG = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FORCE = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy bits for registers awaiting a multi-cycle result, with a three-port hazard lookup.
module rf_scoreboard
   import rf_wb_arbiter_pkg::*;
#(
   parameter int AW   = P_AW,
   parameter int NREG = P_NREG
)(
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_set,
   input  logic [AW-1:0]   i_set_idx,
   input  logic            i_clr,
   input  logic [AW-1:0]   i_clr_idx,
   input  logic [AW-1:0]   i_rs1,
   input  logic [AW-1:0]   i_rs2,
   input  logic [AW-1:0]   i_rd,
   output logic            o_hazard,
   output logic [NREG-1:0] o_busy
);

   logic [NREG-1:0] r_busy;
   logic [NREG-1:0] w_busy_nxt;

   // Next busy vector: the clear is applied first so a same-index set wins.
   always_comb begin
      w_busy_nxt = r_busy;
      if (i_clr) begin
         w_busy_nxt[i_clr_idx] = 1'b0;
      end else begin
         w_busy_nxt = r_busy;
      end
      if (i_set) begin
         w_busy_nxt[i_set_idx] = 1'b1;
      end else begin
         w_busy_nxt[0] = 1'b0;
      end
      w_busy_nxt[0] = 1'b0;
   end

   // Busy vector register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_busy <= '0;
      end else begin
         r_busy <= w_busy_nxt;
      end
   end

   // Hazard lookup for decode.
   always_comb begin
      o_hazard = r_busy[i_rs1] | r_busy[i_rs2] | r_busy[i_rd];
      o_busy   = r_busy;
   end

endmodule

// File: rtl/rf_wb_arbiter_chk.sv
// Simulation-only protocol checks for the write-port arbiter.
module rf_wb_arbiter_chk
   import rf_wb_arbiter_pkg::*;
#(
   parameter int AW   = P_AW,
   parameter int NREG = P_NREG
)(
   input logic            i_clk,
   input logic            i_rst,
   input logic            i_wb_valid,
   input logic [AW-1:0]   i_wb_addr,
   input logic [NREG-1:0] i_busy
);

   // The pipeline must never write a register still owed a multi-cycle result.
   a_wb_not_busy: assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_wb_valid && i_busy[i_wb_addr]));

endmodule

// File: rtl/rf_wb_arbiter.sv
// Arbitrates the register file write port between pipeline writeback and a
// multi-cycle unit, with hazard scoreboard and starvation-driven pipeline hold.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int DW         = P_DW,
   parameter int AW         = P_AW,
   parameter int NREG       = P_NREG,
   parameter int STARVE_MAX = 4
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          wb_valid,
   input  logic [AW-1:0] wb_addr,
   input  logic [DW-1:0] wb_data,
   input  logic          mc_issue,
   input  logic [AW-1:0] mc_issue_rd,
   input  logic          mc_valid,
   input  logic [AW-1:0] mc_addr,
   input  logic [DW-1:0] mc_data,
   output logic          mc_ready,
   input  logic [AW-1:0] dec_rs1,
   input  logic [AW-1:0] dec_rs2,
   input  logic [AW-1:0] dec_rd,
   output logic          dec_stall,
   output logic          pipe_hold,
   output logic          RFWr,
   output logic [AW-1:0] A3,
   output logic [DW-1:0] WD
);

   localparam logic [3:0] L_STARVE_MAX = 4'(STARVE_MAX);

   arb_state_e      r_state;
   arb_state_e      w_state_nxt;
   logic [3:0]      r_starve_cnt;
   logic [3:0]      w_starve_nxt;
   logic            r_pipe_hold;
   logic            w_pipe_hold_nxt;
   logic [AW-1:0]   r_hold_addr;
   logic [DW-1:0]   r_hold_data;
   logic [AW-1:0]   r_last_a3;
   logic [DW-1:0]   r_last_wd;
   logic            w_hold_valid;
   logic            w_capture;
   logic            w_drain;
   logic            w_src;
   logic [AW-1:0]   w_a3;
   logic [DW-1:0]   w_wd;
   logic            w_sb_hazard;
   logic            w_hold_hit;
   logic [NREG-1:0] w_busy;
   logic [3:0]      w_cnt_inc;

   // Handshake and drain qualifiers; the hold entry is live in WAIT and FORCE.
   always_comb begin
      w_hold_valid = (r_state != ST_IDLE);
      w_capture    = mc_valid & ~w_hold_valid;
      w_drain      = w_hold_valid & ~wb_valid;
      w_cnt_inc    = r_starve_cnt + 4'd1;
   end

   // FSM next state, starvation counter and pipeline-hold request.
   always_comb begin
      w_state_nxt     = r_state;
      w_starve_nxt    = r_starve_cnt;
      w_pipe_hold_nxt = r_pipe_hold;
      case (r_state)
         ST_IDLE: begin
            if (w_capture) begin
               w_state_nxt     = ST_WAIT;
               w_starve_nxt    = 4'd0;
               w_pipe_hold_nxt = 1'b0;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_WAIT, ST_FORCE: begin
            if (w_drain) begin
               w_state_nxt     = w_capture ? ST_WAIT : ST_IDLE;
               w_starve_nxt    = 4'd0;
               w_pipe_hold_nxt = 1'b0;
            end else if (r_state == ST_WAIT) begin
               w_starve_nxt = w_cnt_inc;
               if (w_cnt_inc == L_STARVE_MAX) begin
                  w_state_nxt     = ST_FORCE;
                  w_pipe_hold_nxt = 1'b1;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end else begin
               // In-flight writeback keeps priority while the hold is forced.
               w_state_nxt     = ST_FORCE;
               w_pipe_hold_nxt = 1'b1;
            end
         end
         default: begin
            w_state_nxt     = ST_IDLE;
            w_starve_nxt    = 4'd0;
            w_pipe_hold_nxt = 1'b0;
         end
      endcase
   end

   // FSM state, counter and pipe_hold registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_starve_cnt <= 4'd0;
         r_pipe_hold  <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_pipe_hold  <= w_pipe_hold_nxt;
      end
   end

   // Single-entry holding register for multi-cycle results.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hold_addr <= '0;
         r_hold_data <= '0;
      end else if (w_capture) begin
         r_hold_addr <= mc_addr;
         r_hold_data <= mc_data;
      end else begin
         r_hold_addr <= r_hold_addr;
         r_hold_data <= r_hold_data;
      end
   end

   // Write-port mux: pipeline first, then the hold entry, else hold last values.
   always_comb begin
      if (wb_valid) begin
         w_a3  = wb_addr;
         w_wd  = wb_data;
         w_src = 1'b1;
      end else if (w_hold_valid) begin
         w_a3  = r_hold_addr;
         w_wd  = r_hold_data;
         w_src = 1'b1;
      end else begin
         w_a3  = r_last_a3;
         w_wd  = r_last_wd;
         w_src = 1'b0;
      end
   end

   // Remember the last driven address/data for idle cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_a3 <= '0;
         r_last_wd <= '0;
      end else if (w_src) begin
         r_last_a3 <= w_a3;
         r_last_wd <= w_wd;
      end else begin
         r_last_a3 <= r_last_a3;
         r_last_wd <= r_last_wd;
      end
   end

   rf_scoreboard #(
      .AW   (AW),
      .NREG (NREG)
   ) u_scoreboard (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_set     (mc_issue & (mc_issue_rd != '0)),
      .i_set_idx (mc_issue_rd),
      .i_clr     (w_drain),
      .i_clr_idx (r_hold_addr),
      .i_rs1     (dec_rs1),
      .i_rs2     (dec_rs2),
      .i_rd      (dec_rd),
      .o_hazard  (w_sb_hazard),
      .o_busy    (w_busy)
   );

   rf_wb_arbiter_chk #(
      .AW   (AW),
      .NREG (NREG)
   ) u_chk (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_wb_valid (wb_valid),
      .i_wb_addr  (wb_addr),
      .i_busy     (w_busy)
   );

   // Output drive; a pending hold entry also counts as a hazard (x0 never does).
   always_comb begin
      w_hold_hit = w_hold_valid & (r_hold_addr != '0) &
                   ((r_hold_addr == dec_rs1) | (r_hold_addr == dec_rs2) |
                    (r_hold_addr == dec_rd));
      dec_stall  = w_sb_hazard | w_hold_hit;
      mc_ready   = ~w_hold_valid;
      pipe_hold  = r_pipe_hold;
      RFWr       = w_src & (w_a3 != '0);
      A3         = w_a3;
      WD         = w_wd;
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed and random checks of rf_wb_arbiter against a rule-level reference model.
module tb_rf_wb_arbiter;

   localparam int SM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        mc_issue;
   logic [4:0]  mc_issue_rd;
   logic        mc_valid;
   logic [4:0]  mc_addr;
   logic [31:0] mc_data;
   logic        mc_ready;
   logic [4:0]  dec_rs1, dec_rs2, dec_rd;
   logic        dec_stall, pipe_hold, RFWr;
   logic [4:0]  A3;
   logic [31:0] WD;

   int total = 0;
   int bad   = 0;

   // reference model: pending result, owed registers, blocked-cycle count
   bit          m_known  = 1'b0;
   bit          m_lknown = 1'b0;
   bit          m_busy [32];
   bit          m_hold;
   logic [4:0]  m_haddr;
   logic [31:0] m_hdata;
   int          m_blocked;
   logic [4:0]  m_la3;
   logic [31:0] m_lwd;

   always #5 clk = ~clk;

   rf_wb_arbiter #(.DW(32), .AW(5), .NREG(32), .STARVE_MAX(SM)) dut (
      .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
      .mc_issue(mc_issue), .mc_issue_rd(mc_issue_rd), .mc_valid(mc_valid),
      .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready),
      .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_stall(dec_stall),
      .pipe_hold(pipe_hold), .RFWr(RFWr), .A3(A3), .WD(WD)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rst = 1'b0; wb_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
      mc_issue = 1'b0; mc_issue_rd = 5'd0; mc_valid = 1'b0; mc_addr = 5'd0; mc_data = 32'd0;
      dec_rs1 = 5'd0; dec_rs2 = 5'd0; dec_rd = 5'd0;
   endtask

   task automatic check_model();
      logic [4:0]  ea3;
      logic [31:0] ewd;
      logic        ewr, est, ehold, show;
      if (m_known) begin
         show = 1'b1;
         if (wb_valid) begin
            ea3 = wb_addr; ewd = wb_data; ewr = (wb_addr != 5'd0);
         end else if (m_hold) begin
            ea3 = m_haddr; ewd = m_hdata; ewr = (m_haddr != 5'd0);
         end else begin
            ea3 = m_la3; ewd = m_lwd; ewr = 1'b0; show = m_lknown;
         end
         est = m_busy[dec_rs1] | m_busy[dec_rs2] | m_busy[dec_rd] |
               (m_hold && m_haddr != 5'd0 &&
                (m_haddr == dec_rs1 || m_haddr == dec_rs2 || m_haddr == dec_rd));
         ehold = m_hold && (m_blocked >= SM);
         chk("mc_ready", 32'(mc_ready), 32'(!m_hold));
         chk("RFWr", 32'(RFWr), 32'(ewr));
         chk("dec_stall", 32'(dec_stall), 32'(est));
         chk("pipe_hold", 32'(pipe_hold), 32'(ehold));
         if (show) begin
            chk("A3", 32'(A3), 32'(ea3));
            chk("WD", WD, ewd);
         end
      end
   endtask

   task automatic update_model();
      bit drain, cap;
      if (rst) begin
         foreach (m_busy[i]) m_busy[i] = 1'b0;
         m_hold = 1'b0; m_blocked = 0; m_known = 1'b1; m_lknown = 1'b0;
      end else begin
         drain = m_hold && !wb_valid;
         cap   = mc_valid && !m_hold;
         if (wb_valid) begin
            m_la3 = wb_addr; m_lwd = wb_data; m_lknown = 1'b1;
         end else if (m_hold) begin
            m_la3 = m_haddr; m_lwd = m_hdata; m_lknown = 1'b1;
         end
         if (drain) m_busy[m_haddr] = 1'b0;
         if (mc_issue && mc_issue_rd != 5'd0) m_busy[mc_issue_rd] = 1'b1;
         if (m_hold && wb_valid) m_blocked++;
         if (drain) begin m_hold = 1'b0; m_blocked = 0; end
         if (cap) begin m_hold = 1'b1; m_haddr = mc_addr; m_hdata = mc_data; m_blocked = 0; end
      end
   endtask

   // inputs are expected to be settled (#2 after being driven) when step is called
   task automatic step();
      check_model();
      @(posedge clk);
      update_model();
      #1;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      #1;
      step(); step();
      idle(); #2;
      chk("rst_ready", 32'(mc_ready), 32'd1);
      chk("rst_rfwr", 32'(RFWr), 32'd0);
      chk("rst_phold", 32'(pipe_hold), 32'd0);
      step();

      // 1: result latency through the holding register
      mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'hDEAD_BEEF; #2;
      chk("t1_ready", 32'(mc_ready), 32'd1);
      chk("t1_nobypass", 32'(RFWr), 32'd0);
      step();
      idle(); #2;
      chk("t1_wr", 32'(RFWr), 32'd1);
      chk("t1_a3", 32'(A3), 32'd5);
      chk("t1_wd", WD, 32'hDEAD_BEEF);
      step();
      #2; chk("t1_done", 32'(RFWr), 32'd0); chk("t1_a3_held", 32'(A3), 32'd5);
      step();

      // 2: issue-to-decode visibility and clear after drain
      mc_issue = 1'b1; mc_issue_rd = 5'd7; dec_rs1 = 5'd7; #2;
      chk("t2_same_cycle", 32'(dec_stall), 32'd0);
      step();
      idle(); dec_rs1 = 5'd7; #2; chk("t2_stall", 32'(dec_stall), 32'd1); step();
      mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h77; #2; step();
      mc_valid = 1'b0; #2; chk("t2_drain_stall", 32'(dec_stall), 32'd1); chk("t2_drain_a3", 32'(A3), 32'd7); step();
      #2; chk("t2_clear", 32'(dec_stall), 32'd0); step();

      // 3: starvation forces a pipeline hold
      idle(); mc_valid = 1'b1; mc_addr = 5'd3; mc_data = 32'h33; #2; step();
      idle(); wb_valid = 1'b1; wb_addr = 5'd10; wb_data = 32'hA0;
      for (int i = 0; i < SM; i++) begin
         #2; chk("t3_no_hold", 32'(pipe_hold), 32'd0); step();
      end
      #2; chk("t3_hold", 32'(pipe_hold), 32'd1); chk("t3_inflight_a3", 32'(A3), 32'd10); step();
      wb_valid = 1'b0; #2;
      chk("t3_hold2", 32'(pipe_hold), 32'd1);
      chk("t3_drain_wr", 32'(RFWr), 32'd1);
      chk("t3_drain_a3", 32'(A3), 32'd3);
      step();
      #2; chk("t3_release", 32'(pipe_hold), 32'd0); step();

      // 4: pipeline has priority over a pending result
      idle(); mc_valid = 1'b1; mc_addr = 5'd4; mc_data = 32'd2; #2; step();
      idle(); wb_valid = 1'b1; wb_addr = 5'd9; wb_data = 32'd1; #2;
      chk("t4_a3", 32'(A3), 32'd9); chk("t4_wd", WD, 32'd1); chk("t4_ready", 32'(mc_ready), 32'd0);
      step();
      idle(); #2; chk("t4_a3b", 32'(A3), 32'd4); chk("t4_wdb", WD, 32'd2); chk("t4_wrb", 32'(RFWr), 32'd1);
      step();

      // 5: x0 is never tracked nor written
      mc_issue = 1'b1; mc_issue_rd = 5'd0; #2; step();
      idle(); mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'd5; #2; step();
      idle(); #2; chk("t5_wr", 32'(RFWr), 32'd0); chk("t5_stall", 32'(dec_stall), 32'd0); step();

      // 6: reset discards pending state
      mc_issue = 1'b1; mc_issue_rd = 5'd12; mc_valid = 1'b1; mc_addr = 5'd12; mc_data = 32'd8; #2; step();
      idle(); rst = 1'b1; #2; step();
      idle(); dec_rs1 = 5'd12; #2;
      chk("t6_ready", 32'(mc_ready), 32'd1); chk("t6_stall", 32'(dec_stall), 32'd0); chk("t6_wr", 32'(RFWr), 32'd0);
      step();

      // 7: set and clear of the same register in one cycle keeps it busy
      mc_issue = 1'b1; mc_issue_rd = 5'd6; mc_valid = 1'b1; mc_addr = 5'd6; mc_data = 32'd60; #2; step();
      idle(); mc_issue = 1'b1; mc_issue_rd = 5'd6; #2; step();
      idle(); dec_rs2 = 5'd6; #2; chk("t7_set_wins", 32'(dec_stall), 32'd1); step();

      // random traffic
      for (int n = 0; n < 600; n++) begin
         idle();
         rst         = ($urandom_range(0, 63) == 0);
         wb_valid    = !(m_hold && m_blocked >= SM) && ($urandom_range(0, 2) != 0);
         wb_addr     = 5'($urandom_range(0, 7));
         if (m_busy[wb_addr]) wb_addr = 5'd0;
         wb_data     = $urandom;
         mc_issue    = ($urandom_range(0, 3) == 0);
         mc_issue_rd = 5'($urandom_range(0, 7));
         mc_valid    = ($urandom_range(0, 2) == 0);
         mc_addr     = 5'($urandom_range(0, 7));
         mc_data     = $urandom;
         dec_rs1     = 5'($urandom_range(0, 7));
         dec_rs2     = 5'($urandom_range(0, 7));
         dec_rd      = 5'($urandom_range(0, 7));
         #2;
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
